pipe_skid_reg: RTL and testbench

- Parametrised, elastic successor to the fixed IF/ID stage register.
- Carries an instruction word plus its PC between two pipeline stages using a valid/ready handshake, with a 2-entry skid buffer.
- Upstream is never stalled combinationally by downstream.
- Adds a flush/kill capability: killed or empty slots present a NOP bubble, so decode never sees stale data.

---
 rtl/pipe_skid_reg_pkg.sv | 26 ++
 rtl/pipe_skid_reg_if.sv | 37 +++
 rtl/pipe_slot_reg.sv | 37 +++
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared definitions for the elastic IF/ID stage register: default widths,
// bubble values, the occupancy/state encoding and a packed {instr, pc} entry.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

   localparam int          INSTR_W_DEF   = 32;
   localparam int          ADDR_W_DEF    = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

   // State value doubles as the occupancy count presented on the port.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [ADDR_W_DEF-1:0]  pc;
   } entry_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
// Handshake bundle for pipe_skid_reg.
//   flush                      : synchronous kill of held entries and same-cycle input
//   in_valid/in_ready          : upstream handshake
//   in_instr/in_pc             : upstream entry
//   out_valid/out_ready        : downstream handshake
//   out_instr/out_pc           : head entry (bubble when out_valid = 0)
//   occupancy                  : number of held entries, 0..2
// master = environment side (upstream producer + downstream consumer),
// slave  = the stage register itself.
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 32
);
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [ADDR_W-1:0]  in_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [1:0]         occupancy;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, occupancy
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, occupancy
   );
endinterface

// File: rtl/pipe_slot_reg.sv
// -----------------------------------------------------------------------------
// pipe_slot_reg
// One entry-wide storage register with load enable and bubble load.
//   clk      : clock
//   rst      : async active-high reset, loads BUBBLE
//   load_i   : capture d_i
//   bubble_i : load BUBBLE (wins over load_i)
//   d_i      : entry to capture
//   q_o      : stored entry
// -----------------------------------------------------------------------------
module pipe_slot_reg #(
   parameter int           W      = 64,
   parameter logic [W-1:0] BUBBLE = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= BUBBLE;
      end else if (bubble_i) begin
         slot_q <= BUBBLE;
      end else if (load_i) begin
         slot_q <= d_i;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic IF/ID stage register with a 2-entry skid buffer and flush.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : pipe_skid_reg_if.slave (handshake, data, flush, occupancy)
// The main slot always drives the outputs; the skid slot only catches the
// entry accepted while the head is stalled, so in_ready depends on registered
// state alone and never on out_ready.
// -----------------------------------------------------------------------------
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter int                 ADDR_W    = ADDR_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
   parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   pipe_skid_reg_if.slave bus
);

   localparam int           W      = INSTR_W + ADDR_W;
   localparam logic [W-1:0] BUBBLE = {NOP_INSTR, RESET_PC};

   state_e       state_q, state_d;
   logic         acc, pop;
   logic         main_load, main_bubble, skid_load, skid_bubble;
   logic [W-1:0] in_entry, main_d, main_q, skid_q;

   assign bus.in_ready  = (state_q != ST_FULL) & ~rst;
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.occupancy = state_q;

   assign acc      = bus.in_valid & bus.in_ready;
   assign pop      = bus.out_valid & bus.out_ready;
   assign in_entry = {bus.in_instr, bus.in_pc};

   // Slots only load on an accepted transfer, so input data with
   // in_valid = 0 never reaches storage.
   always_comb begin
      state_d     = state_q;
      main_d      = in_entry;
      main_load   = 1'b0;
      main_bubble = 1'b0;
      skid_load   = 1'b0;
      skid_bubble = 1'b0;
      if (bus.flush) begin
         // Same-cycle accept is dropped; same-cycle pop has already happened.
         state_d     = ST_EMPTY;
         main_bubble = 1'b1;
         skid_bubble = 1'b1;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  main_load = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  main_load = 1'b1;
               end else if (acc) begin
                  skid_load = 1'b1;
                  state_d   = ST_FULL;
               end else if (pop) begin
                  main_bubble = 1'b1;
                  state_d     = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  main_d      = skid_q;
                  main_load   = 1'b1;
                  skid_bubble = 1'b1;
                  state_d     = ST_ONE;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_bubble = 1'b1;
               skid_bubble = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_slot_reg #(.W(W), .BUBBLE(BUBBLE)) u_main (
      .clk      (clk),
      .rst      (rst),
      .load_i   (main_load),
      .bubble_i (main_bubble),
      .d_i      (main_d),
      .q_o      (main_q)
   );

   pipe_slot_reg #(.W(W), .BUBBLE(BUBBLE)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load_i   (skid_load),
      .bubble_i (skid_bubble),
      .d_i      (in_entry),
      .q_o      (skid_q)
   );

   assign bus.out_instr = main_q[W-1:ADDR_W];
   assign bus.out_pc    = main_q[ADDR_W-1:0];

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg: directed scenarios followed by a
// randomised valid/ready/flush run, with a queue scoreboard tracking entries
// accepted minus those consumed or flushed.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;
   import pipe_skid_reg_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic clk;
   logic rst;

   pipe_skid_reg_if #(.INSTR_W(32), .ADDR_W(32)) bus ();

   pipe_skid_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_chk  = 0;
   int     n_pass = 0;
   entry_t sb_q[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = v;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   // Scoreboard monitor: inputs are stable across the negedge, so what is
   // seen here is exactly what the next rising edge will act on.
   always @(negedge clk) begin
      entry_t exp_e;
      if (rst) begin
         sb_q.delete();
      end else begin
         check_val("occupancy", 64'(bus.occupancy), 64'(sb_q.size()));
         check_val("out_valid", 64'(bus.out_valid), 64'(sb_q.size() != 0));
         check_val("in_ready", 64'(bus.in_ready), 64'(sb_q.size() < 2));
         if (sb_q.size() == 0)
            check_val("bubble", {bus.out_instr, bus.out_pc}, {NOP, RPC});
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() != 0) begin
               exp_e = sb_q.pop_front();
               check_val("pop_data", {bus.out_instr, bus.out_pc}, {exp_e.instr, exp_e.pc});
            end
         end
         if (bus.flush) begin
            sb_q.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back('{instr: bus.in_instr, pc: bus.in_pc});
         end
      end
   end

   logic [31:0] pc_ctr;
   logic        rdy_before;

   initial begin
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #2;
      check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_occ", 64'(bus.occupancy), 64'd0);
      check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("rst_out", {bus.out_instr, bus.out_pc}, {NOP, RPC});
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check_val("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Streaming with out_ready high
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h11, 32'h00);
      tick();
      check_val("stream0", {bus.out_instr, bus.out_pc}, {32'h11, 32'h00});
      check_val("stream0_occ", 64'(bus.occupancy), 64'd1);
      drive(1'b1, 32'h22, 32'h04);
      tick();
      check_val("stream1", {bus.out_instr, bus.out_pc}, {32'h22, 32'h04});
      check_val("stream1_rdy", 64'(bus.in_ready), 64'd1);
      drive(1'b1, 32'h33, 32'h08);
      tick();
      check_val("stream2", {bus.out_instr, bus.out_pc}, {32'h33, 32'h08});
      check_val("stream2_occ", 64'(bus.occupancy), 64'd1);
      drive(1'b0, 32'hDEAD, 32'hBEEF);
      tick();
      check_val("stream_empty", {bus.out_instr, bus.out_pc}, {NOP, RPC});

      // Backpressure
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hA0, 32'h100);
      tick();
      drive(1'b1, 32'hA4, 32'h104);
      tick();
      check_val("bp_occ", 64'(bus.occupancy), 64'd2);
      check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("bp_head", 64'(bus.out_pc), 64'h100);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check_val("bp_hold", {bus.out_instr, bus.out_pc}, {32'hA0, 32'h100});
      bus.out_ready = 1'b1;
      tick();
      check_val("bp_second", {bus.out_instr, bus.out_pc}, {32'hA4, 32'h104});
      check_val("bp_second_occ", 64'(bus.occupancy), 64'd1);
      tick();
      check_val("bp_drained", 64'(bus.occupancy), 64'd0);

      // Drain from ONE, then refill
      drive(1'b1, 32'hB0, 32'h2FC);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check_val("drain_occ", 64'(bus.occupancy), 64'd0);
      check_val("drain_pc", 64'(bus.out_pc), 64'(RPC));
      drive(1'b1, 32'hC0, 32'h300);
      tick();
      check_val("refill", {bus.out_instr, bus.out_pc}, {32'hC0, 32'h300});
      drive(1'b0, 32'h0, 32'h0);
      tick();

      // Flush while FULL with input presented
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hD0, 32'h1F0);
      tick();
      drive(1'b1, 32'hD4, 32'h1F4);
      tick();
      check_val("fl_full_occ", 64'(bus.occupancy), 64'd2);
      bus.flush = 1'b1;
      drive(1'b1, 32'h44, 32'h200);
      tick();
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check_val("fl_full_after", {62'(bus.occupancy), bus.out_valid}, 64'd0);
      check_val("fl_full_nop", 64'(bus.out_instr), 64'(NOP));
      bus.out_ready = 1'b1;
      tick();
      check_val("fl_full_no200", 64'(bus.out_valid), 64'd0);

      // Flush in ONE with an accepted input: the input is dropped
      drive(1'b1, 32'h55, 32'h2F0);
      tick();
      bus.flush     = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h66, 32'h200);
      tick();
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check_val("fl_one_occ", 64'(bus.occupancy), 64'd0);
      check_val("fl_one_out", {bus.out_instr, bus.out_pc}, {NOP, RPC});
      tick();
      check_val("fl_one_no200", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset mid-cycle while FULL
      drive(1'b1, 32'hE0, 32'h400);
      tick();
      drive(1'b1, 32'hE4, 32'h404);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      check_val("ar_full", 64'(bus.occupancy), 64'd2);
      #2 rst = 1'b1;
      #1;
      check_val("ar_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("ar_out", {bus.out_instr, bus.out_pc}, {NOP, RPC});
      check_val("ar_occ", 64'(bus.occupancy), 64'd0);
      check_val("ar_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check_val("ar_release_rdy", 64'(bus.in_ready), 64'd1);
      check_val("ar_release_occ", 64'(bus.occupancy), 64'd0);

      // Random valid/ready with sporadic flush
      pc_ctr = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, pc_ctr);
         pc_ctr        = pc_ctr + 32'd4;
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.flush     = ($urandom_range(0, 99) < 2);
         #2;
         rdy_before    = bus.in_ready;
         bus.out_ready = 1'($urandom_range(0, 1));
         #1;
         check_val("in_ready_vs_out_ready", 64'(bus.in_ready), 64'(rdy_before));
         @(posedge clk);
         #1;
      end

      drive(1'b0, 32'h0, 32'h0);
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check_val("final_occ", 64'(bus.occupancy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
